// File: rtl/serial_adder_unit.sv
// Bit-serial WIDTH-bit adder: a single full-adder cell plus a carry flop,
// processing the operands LSB first, one bit per clock.
module serial_adder_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] areg, breg, preg;
   logic [CW-1:0]    cnt;
   logic             c;
   logic             s, nc;

   // the one full-adder cell shared by every bit position
   always_comb begin
      s  = areg[0] ^ breg[0] ^ c;
      nc = (areg[0] & breg[0]) | (areg[0] & c) | (breg[0] & c);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         areg  <= '0;
         breg  <= '0;
         preg  <= '0;
         cnt   <= '0;
         c     <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  areg  <= a;
                  breg  <= b;
                  c     <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               preg <= {s, preg[WIDTH-1:1]};
               areg <= areg >> 1;
               breg <= breg >> 1;
               c    <= nc;
               if (cnt == LAST) begin
                  // c is still the carry into the MSB here, nc the carry out of it
                  sum   <= {s, preg[WIDTH-1:1]};
                  cout  <= nc;
                  ovf   <= c ^ nc;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder_unit.sv
// Scoreboard bench for serial_adder_unit: stimulus pushes the arithmetic
// reference result, a monitor pops and compares on every done pulse.
module tb_serial_adder_unit;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout, ovf;
   logic [W-1:0] sum;

   serial_adder_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   done_cnt = 0;
   int   cyc = 0;
   int   last_done_cyc = 0;
   bit   held_mode = 0;
   bit   have_prev = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // reference: plain integer addition; overflow from operand/result signs
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      exp_t e;
      int   t;
      t      = int'(x) + int'(y) + int'(ci);
      e.sum  = t[W-1:0];
      e.cout = t[W];
      e.ovf  = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      if (!rst && done) begin
         exp_t e;
         done_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no result pending");
         end else begin
            e = exp_q.pop_front();
            chk("sum", int'(sum), int'(e.sum));
            chk("cout", int'(cout), int'(e.cout));
            chk("ovf", int'(ovf), int'(e.ovf));
            chk("busy_at_done", int'(busy), 0);
         end
         if (held_mode && have_prev) chk("done_period", cyc - last_done_cyc, W + 2);
         have_prev     = 1'b1;
         last_done_cyc = cyc;
      end
   end

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      a = x; b = y; cin = ci;
      exp_q.push_back(model(x, y, ci));
   endtask

   // single op from IDLE: start pulse, count busy cycles until done
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      int  nb;
      bit  seen;
      issue(x, y, ci);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom; b = $urandom; cin = $urandom;
      nb = 0; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
         else if (busy) nb++;
      end
      chk("done_seen", int'(seen), 1);
      chk("busy_cycles", nb, W);
      @(posedge clk); #1;
   endtask

   initial begin
      int d0;
      // 1. reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_sum", int'(sum), 0);
      chk("rst_cout", int'(cout), 0);
      chk("rst_ovf", int'(ovf), 0);
      repeat (3) @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      @(posedge clk); #1;

      // 2, 3. directed sums
      run_op(8'hFF, 8'h01, 1'b0);
      run_op(8'h7F, 8'h01, 1'b0);
      run_op(8'hA5, 8'h5A, 1'b1);

      // 4. start ignored in SHIFT and DONE
      d0 = done_cnt;
      issue(8'h12, 8'h34, 1'b0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 a = 8'hFF; b = 8'hFF; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 40 && !done; i++) @(negedge clk);
      chk("t4_done", int'(done), 1);
      a = 8'hFF; b = 8'hFF; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (14) @(negedge clk);
      chk("t4_one_done", done_cnt - d0, 1);
      chk("t4_idle", int'(busy), 0);
      @(posedge clk); #1;

      // 5. asynchronous reset mid-operation
      d0 = done_cnt;
      a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_sum", int'(sum), 0);
      chk("abort_cout", int'(cout), 0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      @(posedge clk); #1;
      run_op(8'h0F, 8'h01, 1'b0);

      // 6. start held high, random operands
      held_mode = 1'b1;
      have_prev = 1'b0;
      d0 = done_cnt;
      issue(W'($urandom), W'($urandom), 1'($urandom));
      start = 1'b1;
      @(posedge clk);
      for (int i = 1; i < 200; i++) begin
         #1 issue(W'($urandom), W'($urandom), 1'($urandom));
         repeat (W + 2) @(posedge clk);
      end
      #1 start = 1'b0;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
      chk("pending_results", exp_q.size(), 0);
      repeat (12) @(negedge clk);
      chk("held_done_count", done_cnt - d0, 200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
